gray_decoder: RTL and testbench

GRAY_DECODER -- requirements
Module: gray_decoder

---
 rtl/gray_decoder.sv | 109 ++++++++++
 tb/tb_gray_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - Gray-to-binary decoder with sequence lock tracking and error counter
module gray_decoder #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [ERRW-1:0]  err_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [ERRW-1:0]  ERR_MAX  = {ERRW{1'b1}};
  localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_bin;
  logic             r_bin_valid;
  logic             r_locked;
  logic             r_step_err;
  logic [ERRW-1:0]  r_err_count;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_delta;
  logic             w_hold;
  logic             w_step;
  logic             w_break;

  // Each binary bit is the XOR of the gray bit at that position and every bit above it.
  always_comb begin
    w_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bin[i] = ^(gray_in >> i);
    end
  end

  // Classify the new sample against the previous one; modular subtraction makes 2^W-1 -> 0 a +1 step.
  always_comb begin
    w_delta = w_bin - r_prev;
    w_hold  = (w_delta == '0);
    w_step  = (w_delta == DELTA_UP);
    w_break = !(w_hold || w_step);
  end

  // Sequence-tracking FSM; every output is registered here so pulses align with bin_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prev      <= '0;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_bin_valid <= 1'b0;
      r_step_err  <= 1'b0;
      if (in_valid) begin
        r_bin_valid <= 1'b1;
        r_bin       <= w_bin;
        r_prev      <= w_bin;
        case (r_state)
          ST_IDLE: begin
            r_state  <= ST_ACQ;
            r_locked <= 1'b0;
          end
          ST_ACQ: begin
            if (w_step) begin
              r_state  <= ST_LOCK;
              r_locked <= 1'b1;
            end
          end
          ST_LOCK: begin
            if (w_break) begin
              r_state    <= ST_ACQ;
              r_locked   <= 1'b0;
              r_step_err <= 1'b1;
              if (r_err_count != ERR_MAX) begin
                r_err_count <= r_err_count + ERRW'(1);
              end
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bin_out   = r_bin;
  assign bin_valid = r_bin_valid;
  assign locked    = r_locked;
  assign step_err  = r_step_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - scoreboard bench for gray_decoder with randomized streams
module tb_gray_decoder;

  localparam int WIDTH = 4;
  localparam int ERRW  = 2;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int EMAX  = (1 << ERRW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             locked;
  logic             step_err;
  logic [ERRW-1:0]  err_count;

  gray_decoder #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .gray_in(gray_in),
    .bin_out(bin_out),
    .bin_valid(bin_valid),
    .locked(locked),
    .step_err(step_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    bit lck;
    bit serr;
    int err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   dec_tab[1 << WIDTH];

  bit   m_have_ref;
  bit   m_locked;
  int   m_prev;
  int   m_err;
  int   mon_last_bin;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int enc(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic model_reset();
    m_have_ref   = 1'b0;
    m_locked     = 1'b0;
    m_prev       = 0;
    m_err        = 0;
    mon_last_bin = 0;
    q.delete();
  endtask

  task automatic model_sample(input int g);
    exp_t e;
    int   b;
    int   d;
    b      = dec_tab[g & MASK];
    d      = (b - m_prev) & MASK;
    e.serr = 1'b0;
    if (!m_have_ref) begin
      m_have_ref = 1'b1;
      m_locked   = 1'b0;
    end else if (d == 1) begin
      m_locked = 1'b1;
    end else if (d != 0) begin
      if (m_locked) begin
        e.serr = 1'b1;
        if (m_err < EMAX) m_err++;
      end
      m_locked = 1'b0;
    end
    m_prev = b;
    e.bin  = b;
    e.lck  = m_locked;
    e.err  = m_err;
    q.push_back(e);
  endtask

  task automatic send(input bit v, input int g);
    @(negedge clk);
    in_valid = v;
    gray_in  = WIDTH'(g);
    if (v) model_sample(g);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bin_out"}, bin_out, 0);
    check({tag, "_bin_valid"}, bin_valid, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_step_err"}, step_err, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    in_valid = 1'b1;
    gray_in  = WIDTH'($urandom_range(MASK));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per bin_valid, otherwise checks idle behaviour.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mon_last_bin = 0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        check("bin_valid", bin_valid, 1);
        check("bin_out", bin_out, e.bin);
        check("locked", locked, e.lck);
        check("step_err", step_err, e.serr);
        check("err_count", err_count, e.err);
        mon_last_bin = e.bin;
      end else begin
        check("idle_bin_valid", bin_valid, 0);
        check("idle_step_err", step_err, 0);
        check("idle_bin_hold", bin_out, mon_last_bin);
      end
    end
  end

  initial begin
    int b;
    int r;
    for (int i = 0; i <= MASK; i++) dec_tab[enc(i)] = i;
    model_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    gray_in  = '0;
    #1;
    rst = 1'b1;
    #2;
    check_all_zero("por");
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // first four counts
    for (int i = 0; i < 4; i++) send(1'b1, enc(i));
    send(1'b0, 0);

    // full count with wrap back to zero
    mid_reset("rst_a");
    for (int i = 0; i < 17; i++) send(1'b1, enc(i & MASK));
    send(1'b0, 0);

    // break while locked, then re-lock
    send(1'b1, 4'b0001);
    send(1'b1, 4'b0010);
    send(1'b1, 4'b0110);

    // repeated sample with gaps
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 4'b0011);
      send(1'b0, 4'b0011);
      send(1'b0, 0);
    end
    send(1'b1, enc(3));
    send(1'b0, 0);

    // asynchronous reset while locked with err_count=2
    mid_reset("rst_b");
    send(1'b1, enc(5));
    send(1'b1, enc(6));

    // saturating error counter
    b = 6;
    for (int i = 0; i < 5; i++) begin
      b = (b + 5) & MASK;
      send(1'b1, enc(b));
      b = (b + 1) & MASK;
      send(1'b1, enc(b));
    end
    send(1'b0, 0);

    // randomized stream
    mid_reset("rst_c");
    b = $urandom_range(MASK);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 55) b = (b + 1) & MASK;
      else if (r < 80) b = b;
      else b = $urandom_range(MASK);
      send($urandom_range(99) < 70, enc(b));
    end
    send(1'b0, 0);
    send(1'b0, 0);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
